// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control slice: stage indices,
// FSM state encoding and default register-index width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;

  // Bit positions of the pipeline registers in the stall/flush vectors
  localparam int unsigned IF_ID  = 0;
  localparam int unsigned ID_EX  = 1;
  localparam int unsigned EX_MEM = 2;
  localparam int unsigned MEM_WB = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  // One-hot mask for a single pipeline register
  function automatic logic [3:0] stage_bit(input int unsigned idx);
    return 4'(1) << idx;
  endfunction

endpackage

// File: rtl/div_occupancy_cnt.sv
// Divide occupancy countdown: loads DIV_CYCLES-1, decrements on request,
// saturates at zero, and flags the final busy cycle (count <= 1).
module div_occupancy_cnt #(
  parameter int unsigned CNT_WIDTH  = 6,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [CNT_WIDTH-1:0] cnt;

  // Countdown register: clear beats load beats decrement; never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_WIDTH'(DIV_CYCLES - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // Last busy cycle once the count has reached one (or already drained)
  always_comb begin
    done = (cnt <= CNT_WIDTH'(1));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: resolves memory-exception, memory-wait, divide
// occupancy, branch redirect and load-use hazards into one per-cycle
// stall/flush pattern for IF/ID, ID/EX, EX/MEM, MEM/WB plus PC hold.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned DIV_CYCLES     = 32,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_div_start,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      mem_exc,
  output logic                      pc_stall,
  output logic [3:0]                stall,
  output logic [3:0]                flush,
  output logic [3:0]                issue_sel,
  output logic                      div_busy
);

  localparam logic [3:0] MEM_STALL = stage_bit(IF_ID) | stage_bit(ID_EX) | stage_bit(EX_MEM);
  localparam logic [3:0] MEM_FLUSH = stage_bit(MEM_WB);
  localparam logic [3:0] DIV_STALL = stage_bit(IF_ID) | stage_bit(ID_EX);
  localparam logic [3:0] DIV_FLUSH = stage_bit(EX_MEM);
  localparam logic [3:0] RDR_FLUSH = stage_bit(IF_ID) | stage_bit(ID_EX);
  localparam logic [3:0] LU_STALL  = stage_bit(IF_ID);
  localparam logic [3:0] LU_FLUSH  = stage_bit(ID_EX);
  localparam logic [3:0] ALL_FLUSH = '1;

  hz_state_t state, state_nxt;
  logic      div_pend, div_pend_nxt;
  logic      cnt_clear, cnt_load, cnt_dec, cnt_done;
  logic      mem_wait_req;
  logic      mem_wait_act, div_act, load_use;

  assign mem_wait_req = mem_req && !mem_ready;

  div_occupancy_cnt #(
    .CNT_WIDTH  (CNT_WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .done  (cnt_done)
  );

  // State register and pending-divide flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      div_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_pend <= div_pend_nxt;
    end
  end

  // Next-state and counter control; a memory exception overrides everything
  always_comb begin
    state_nxt    = state;
    div_pend_nxt = div_pend;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_wait_req) begin
          state_nxt = ST_MEM_WAIT;
          if (ex_div_start) begin
            div_pend_nxt = 1'b1;
            cnt_load     = 1'b1;
          end
        end else if (ex_div_start) begin
          state_nxt = ST_DIV_BUSY;
          cnt_load  = 1'b1;
        end
      end
      ST_DIV_BUSY: begin
        cnt_dec = 1'b1;
        if (mem_wait_req) begin
          state_nxt    = ST_MEM_WAIT;
          div_pend_nxt = 1'b1;
        end else if (cnt_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        cnt_dec = div_pend;
        if (mem_ready) begin
          state_nxt    = (div_pend && !cnt_done) ? ST_DIV_BUSY : ST_RUN;
          div_pend_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = ST_RUN;
        div_pend_nxt = 1'b0;
      end
    endcase
    if (mem_exc) begin
      state_nxt    = ST_RUN;
      div_pend_nxt = 1'b0;
      cnt_clear    = 1'b1;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
    end
  end

  // Priority-resolved control outputs, forced low while in reset.
  // The wait pattern drops in the cycle mem_ready arrives, even in MEM_WAIT;
  // a divide held pending behind a wait still counts as divide occupancy.
  always_comb begin
    pc_stall  = 1'b0;
    stall     = '0;
    flush     = '0;
    div_busy  = 1'b0;
    mem_wait_act = ((state == ST_MEM_WAIT) || mem_req) && !mem_ready;
    div_act      = (state == ST_DIV_BUSY) || div_pend || (ex_div_start && (state == ST_RUN));
    load_use     = ex_valid && ex_is_load && (ex_rd_addr != '0) &&
                   ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    if (rst_n) begin
      div_busy = div_act;
      if (mem_exc) begin
        flush = ALL_FLUSH;
      end else if (mem_wait_act) begin
        pc_stall = 1'b1;
        stall    = MEM_STALL;
        flush    = MEM_FLUSH;
      end else if (div_act) begin
        pc_stall = 1'b1;
        stall    = DIV_STALL;
        flush    = DIV_FLUSH;
      end else if (ex_redirect) begin
        flush = RDR_FLUSH;
      end else if (load_use) begin
        pc_stall = 1'b1;
        stall    = LU_STALL;
        flush    = LU_FLUSH;
      end
    end
    issue_sel = flush;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int DC = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_used, id_rs2_used, ex_valid, ex_is_load;
  logic          ex_div_start, ex_redirect, mem_req, mem_ready, mem_exc;
  logic          pc_stall, div_busy;
  logic [3:0]    stall, flush, issue_sel;
  logic [13:0]   got;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: waiting on memory, divide occupying EX, remaining divide count
  bit m_wait, m_div;
  int m_cnt;

  always #5 clk = ~clk;

  assign got = {pc_stall, stall, flush, issue_sel, div_busy};

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (RW),
    .DIV_CYCLES     (DC),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd_addr   (ex_rd_addr),
    .ex_div_start (ex_div_start),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_exc      (mem_exc),
    .pc_stall     (pc_stall),
    .stall        (stall),
    .flush        (flush),
    .issue_sel    (issue_sel),
    .div_busy     (div_busy)
  );

  // Expected {pc_stall, stall, flush, issue_sel, div_busy} from the priority rules
  function automatic logic [13:0] expect_out();
    logic       pc, db;
    logic [3:0] st, fl;
    bit         start, wait_now, lu;
    start    = ex_div_start && !m_div && !m_wait;
    wait_now = (m_wait || mem_req) && !mem_ready;
    lu = ex_valid && ex_is_load && (ex_rd_addr != 0) &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
    pc = 0; st = 4'b0000; fl = 4'b0000;
    db = m_div || start;
    if (mem_exc)             fl = 4'b1111;
    else if (wait_now)       begin pc = 1; st = 4'b0111; fl = 4'b1000; end
    else if (m_div || start) begin pc = 1; st = 4'b0011; fl = 4'b0100; end
    else if (ex_redirect)    fl = 4'b0011;
    else if (lu)             begin pc = 1; st = 4'b0001; fl = 4'b0010; end
    return {pc, st, fl, fl, db};
  endfunction

  task automatic model_clear();
    m_wait = 0; m_div = 0; m_cnt = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    bit old_div, old_wait, start;
    int old_cnt;
    @(posedge clk);
    old_div = m_div; old_wait = m_wait; old_cnt = m_cnt;
    start = ex_div_start && !old_div && !old_wait;
    if (mem_exc) begin
      model_clear();
    end else begin
      if (old_div && m_cnt > 0) m_cnt--;
      if (start) begin m_div = 1; m_cnt = DC - 1; end
      if (old_wait) begin
        if (mem_ready) begin
          m_wait = 0;
          if (old_div && old_cnt <= 1) m_div = 0;
        end
      end else if (mem_req && !mem_ready) begin
        m_wait = 1;
      end else if (old_div && old_cnt <= 1) begin
        m_div = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 0; id_rs2_used = 0; ex_valid = 0; ex_is_load = 0;
    ex_div_start = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0; mem_exc = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    ex_div_start = 1; mem_exc = 1; mem_req = 1; ex_redirect = 1;
    #12;
    n_checks++;
    if (got !== 14'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", got, 14'b0);
    end
    set_idle();
    @(negedge clk); rst_n = 1; model_clear();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", got, expect_out());
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd_addr = 5;
    id_rs1_addr = 7; id_rs1_used = 1; id_rs2_addr = 5; id_rs2_used = 1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b1_0001_0010_0010_0) begin
      n_fail++; $display("FAIL load_use_x5: got %b expected %b", got, 14'b1_0001_0010_0010_0);
    end
    tick();
    ex_valid = 0;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL load_use_bubble: got %b expected %b", got, 14'b0);
    end
    tick();
    ex_valid = 1; ex_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL load_use_x0: got %b expected %b", got, 14'b0);
    end
    tick();
    ex_rd_addr = 9; id_rs2_addr = 9; id_rs2_used = 0; id_rs1_addr = 3;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL load_use_unused_src: got %b expected %b", got, 14'b0);
    end
    tick();
    set_idle();
  endtask

  task automatic test_divide();
    int busy_cycles = 0;
    set_idle();
    ex_div_start = 1;
    for (int i = 0; i < DC + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (got !== expect_out()) begin
        n_fail++; $display("FAIL divide_cycle%0d: got %b expected %b", i, got, expect_out());
      end
      if (got === 14'b1_0011_0100_0100_1) busy_cycles++;
      tick();
      ex_div_start = 0;
    end
    n_checks++;
    if (busy_cycles != DC) begin
      n_fail++; $display("FAIL divide_length: got %0d cycles expected %0d", busy_cycles, DC);
    end
    @(negedge clk);
    n_checks++;
    if (div_busy !== 1'b0) begin
      n_fail++; $display("FAIL divide_done_busy: got %b expected 0", div_busy);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (got !== expect_out() || got !== 14'b1_0111_1000_1000_0) begin
        n_fail++; $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, got, 14'b1_0111_1000_1000_0);
      end
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL mem_wait_release: got %b expected %b", got, 14'b0);
    end
    tick();
    set_idle();
  endtask

  task automatic test_redirect();
    set_idle();
    ex_redirect = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd_addr = 4; id_rs1_addr = 4; id_rs1_used = 1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0_0000_0011_0011_0) begin
      n_fail++; $display("FAIL redirect_over_load_use: got %b expected %b", got, 14'b0_0000_0011_0011_0);
    end
    tick();
    ex_valid = 0; mem_req = 1; mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b1_0111_1000_1000_0) begin
      n_fail++; $display("FAIL redirect_under_mem_wait: got %b expected %b", got, 14'b1_0111_1000_1000_0);
    end
    tick();
    ex_redirect = 0; mem_ready = 1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out()) begin
      n_fail++; $display("FAIL redirect_wait_release: got %b expected %b", got, expect_out());
    end
    tick();
    set_idle();
  endtask

  task automatic test_exc_in_div();
    set_idle();
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      n_checks++;
      if (got !== expect_out()) begin
        n_fail++; $display("FAIL exc_div_busy%0d: got %b expected %b", i, got, expect_out());
      end
      tick();
    end
    mem_exc = 1;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0_0000_1111_1111_1) begin
      n_fail++; $display("FAIL exc_flush_all: got %b expected %b", got, 14'b0_0000_1111_1111_1);
    end
    tick();
    mem_exc = 0;
    @(negedge clk);
    n_checks++;
    if (got !== expect_out() || got !== 14'b0) begin
      n_fail++; $display("FAIL exc_div_aborted: got %b expected %b", got, 14'b0);
    end
    tick();
  endtask

  task automatic test_reset_mid_div();
    set_idle();
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    repeat (14) tick();
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (got !== 14'b0) begin
      n_fail++; $display("FAIL reset_mid_div_outputs: got %b expected %b", got, 14'b0);
    end
    @(negedge clk); rst_n = 1; model_clear();
    #1;
    n_checks++;
    if (got !== expect_out() || div_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_div_release: got %b expected %b", got, expect_out());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      id_rs1_addr  = RW'($urandom_range(0, 3));
      id_rs2_addr  = RW'($urandom_range(0, 3));
      ex_rd_addr   = RW'($urandom_range(0, 3));
      id_rs1_used  = $urandom_range(0, 1) == 1;
      id_rs2_used  = $urandom_range(0, 1) == 1;
      ex_valid     = $urandom_range(0, 1) == 1;
      ex_is_load   = $urandom_range(0, 1) == 1;
      ex_div_start = $urandom_range(0, 9) == 0;
      ex_redirect  = $urandom_range(0, 7) == 0;
      mem_req      = $urandom_range(0, 2) == 0;
      mem_ready    = $urandom_range(0, 1) == 1;
      mem_exc      = $urandom_range(0, 49) == 0;
      @(negedge clk);
      n_checks++;
      if (got !== expect_out()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", i, got, expect_out());
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_redirect();
    test_exc_in_div();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit that generates the per-stage Stall, Flush and issue_select qualifiers consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold.
- Detects load-use hazards, branch redirects, multi-cycle divide occupancy, data-memory wait and MEM-stage exceptions.
- Resolves these into one consistent stall/bubble pattern per cycle.

Parameters:
- REG_ADDR_WIDTH, 5, architectural register index width.
- DIV_CYCLES, 32, EX-stage cycles a divide occupies (≥2).
- CNT_WIDTH, 6, divide countdown width; must hold DIV_CYCLES-1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_addr  in  REG_ADDR_WIDTH  ID-stage source 1.
- id_rs2_addr  in  REG_ADDR_WIDTH  ID-stage source 2.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd_addr  in  REG_ADDR_WIDTH  EX destination.
- ex_div_start  in  1  divide entering EX this cycle (single-cycle pulse).
- ex_redirect  in  1  taken branch/jump mispredict resolved in EX.
- mem_req  in  1  MEM stage issuing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- mem_exc  in  1  exception/trap raised by the MEM-stage instruction.
- pc_stall  out  1  hold PC.
- stall  out  4  [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB.
- flush  out  4  same bit order.
- issue_sel  out  4  flush qualifier; equals flush bitwise.
- div_busy  out  1  divide occupying EX.

Behaviour:
- State registers: FSM state {RUN, DIV_BUSY, MEM_WAIT}, div_cnt[CNT_WIDTH], div_pend (divide still running while in MEM_WAIT).
- All state clears asynchronously on rst_n low: state=RUN, div_cnt=0, div_pend=0.
- While rst_n is low, all outputs are forced to 0.
- Outputs are combinational from state and current inputs, so a register stalls in the same cycle the hazard is visible. Zero-latency.
- Downstream registers give Stall priority over Flush. A stage is therefore never both stalled and flushed. Any bit set in flush has the corresponding stall bit cleared.
- Priority, highest first:
  1. mem_exc: flush=4'b1111, stall=0, pc_stall=0. Next state RUN, div_cnt=0, div_pend=0. The divide is aborted.
  2. MEM wait (state MEM_WAIT, or RUN/DIV_BUSY with mem_req && !mem_ready): pc_stall=1, stall=4'b0111, flush=4'b1000.
  3. Divide (state DIV_BUSY, or ex_div_start in RUN): pc_stall=1, stall=4'b0011, flush=4'b0100.
  4. ex_redirect (only when no higher item is active): flush=4'b0011, stall=0, pc_stall=0.
  5. Load-use: ex_valid && ex_is_load && ex_rd_addr!=0 && ((id_rs1_used && id_rs1_addr==ex_rd_addr) || (id_rs2_used && id_rs2_addr==ex_rd_addr)). Drives pc_stall=1, stall=4'b0001, flush=4'b0010.
  6. Otherwise all outputs are 0.
- FSM transitions:
  - RUN -> MEM_WAIT on mem_req && !mem_ready. If ex_div_start occurs in the same cycle, set div_pend and load div_cnt=DIV_CYCLES-1.
  - RUN -> DIV_BUSY on ex_div_start, when there is no mem wait and no exception. Load div_cnt=DIV_CYCLES-1.
  - DIV_BUSY: div_cnt decrements each cycle. At div_cnt==1 go to RUN. The divide result is taken in the next cycle.
  - DIV_BUSY -> MEM_WAIT on a new mem wait. Set div_pend; the counter keeps decrementing.
  - MEM_WAIT: stays until mem_ready. Then go to DIV_BUSY if div_pend && div_cnt>1, else RUN; clear div_pend.
  - The counter saturates at 0; it never wraps.
- div_busy = (state==DIV_BUSY) || div_pend || (ex_div_start && state==RUN).
- ex_div_start is ignored while a divide is already busy.
- Register 0 never causes a load-use hazard.

Decomposition:
- Shared package (Define.v): stage index constants IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3; FSM state encodings; REG_ADDR_WIDTH default.
- One sub-module, div_occupancy_cnt, holds the load/decrement/saturate counter and its done flag.
- Hazard compare and priority mux stay in the top module.

Test Plan:
- Reset asserted mid-DIV_BUSY with div_cnt=17 -> outputs 0 immediately; after release state=RUN and div_busy=0.
- Load in EX to x5, ID reads rs2=x5 -> one cycle of pc_stall=1, stall=0001, flush=0010. Repeat with rd=x0 -> no stall.
- ex_div_start with DIV_CYCLES=32 -> stall=0011, flush=0100 for exactly 32 cycles; div_busy falls on cycle 33.
- mem_req with mem_ready low for 3 cycles -> stall=0111, flush=1000 for 3 cycles; released in the cycle mem_ready=1.
- ex_redirect coincident with load-use -> flush=0011, stall=0, pc_stall=0. Redirect coincident with mem wait -> mem-wait pattern only.
- mem_exc during DIV_BUSY with div_cnt=10 -> flush=1111 that cycle; next cycle state=RUN and div_busy=0.
